wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Round-robin arbiter that lets NM Wishbone classic masters share one Wishbone slave port.
- Typical masters: a bus-functional master and a command sequencer, both driving the I2C controller core register file.
- Grants one master per bus cycle (cyc) and routes ack/err/rty back only to the owner.
- Optional watchdog aborts slave cycles that never terminate.

Parameters:
- NM, 2, number of masters (2..8)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- TIMEOUT_CYC, 255, watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- m_cyc_i  in  NM  per-master cycle request
- m_stb_i  in  NM  per-master strobe
- m_we_i  in  NM  per-master write enable
- m_adr_i  in  NM*AW  flattened addresses; master k at [k*AW +: AW]
- m_dat_i  in  NM*DW  flattened write data
- m_sel_i  in  NM*DW/8  flattened byte selects
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o  out  NM  per-master ack
- m_err_o  out  NM  per-master err
- m_rty_o  out  NM  per-master rty
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_sel_o  out  DW/8  slave byte selects
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave err
- s_rty_i  in  1  slave rty
- gnt_o  out  NM  registered one-hot grant (all zero when idle)

Behaviour:
- Reset (rst low at a clk edge):
  - state=IDLE, gnt_o=0, last-owner pointer=NM-1 (master 0 wins first).
  - s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o/s_dat_o/s_sel_o=0.
  - m_ack_o/m_err_o/m_rty_o=0, m_dat_o=0.
  - Reset mid-cycle drops everything at that edge; no termination is delivered.
- States: IDLE, GRANT, ABORT (ABORT exists only with the optional feature).
- IDLE:
  - If any m_cyc_i is high, select the first requester searching from last+1 upward, modulo NM.
  - Register its one-hot gnt_o and set last to it; go to GRANT.
  - Arbitration latency is 1 clk: request seen at edge N, s_cyc_o high after edge N.
- GRANT:
  - Slave outputs are a combinational mux of the granted master's inputs: s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g].
  - s_ack_i/s_err_i/s_rty_i route combinationally to index g only; all other masters see 0.
  - m_dat_o=s_dat_i at all times.
  - Multiple stb/ack beats inside one cyc stay with the same owner; no preemption.
  - When m_cyc_i[g] is sampled low: gnt_o=0, go to IDLE.
  - There is one mandatory dead cycle between owners, even if another master is waiting.
- Outside GRANT: s_cyc_o=s_stb_o=0 and all m_ack_o/m_err_o/m_rty_o=0.
- Fairness: with all NM masters requesting continuously and releasing after one transfer, grants rotate 0,1,..,NM-1,0.
- Simultaneous events:
  - A request arriving in the same cycle the owner drops cyc is arbitrated in IDLE on the next edge.
  - The owner re-asserting cyc immediately goes behind the other waiters (round-robin pointer).
- A master deasserting cyc while non-granted is simply ignored.
- Slave terminations arriving while s_cyc_o=0 are discarded.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit counter (width $clog2(TIMEOUT_CYC+1)) clears on any slave termination or when not in GRANT.
  - It increments each clk where s_cyc_o&s_stb_o is high and s_ack_i|s_err_i|s_rty_i is low.
  - When the counter equals TIMEOUT_CYC: m_err_o[g] pulses high for exactly 1 clk, state goes to ABORT, and the counter clears.
  - ABORT: s_cyc_o=s_stb_o=0 and no terminations are routed. Return to IDLE once m_cyc_i[g] is sampled low.
- Without the macro: no counter and no ABORT state; a hung slave holds the bus indefinitely.

Decomposition:
- Shared package/include wb_arb_defs: state encodings (IDLE=2'd0, GRANT=2'd1, ABORT=2'd2) and the default TIMEOUT_CYC constant.
- One sub-module, wb_rr_picker: combinational round-robin priority encoder.
  - Inputs: req[NM], last one-hot.
  - Outputs: one-hot pick, valid.
- Everything else (FSM, muxes, watchdog) lives in wb_bus_arbiter.

Test Plan:
- Reset then idle: rst low 3 clk, all m_cyc_i=0 -> gnt_o=0, s_cyc_o=0, all terminations 0.
- Single master write: master 1 writes adr 0x04, dat 0x0000_00A5, slave acks after 2 wait states -> s_adr_o=0x04, s_dat_o=0xA5, m_ack_o=2'b10 for 1 clk, gnt_o=0 one clk after cyc drops.
- Contention: masters 0 and 1 assert cyc in the same clk, each doing reads returning 0x11/0x22, then re-requesting -> grant order 0,1,0,1 with one dead cycle between; m_ack_o never reaches the non-owner.
- Reset mid-cycle: rst low while master 0 is waiting for ack -> next edge s_cyc_o=0, gnt_o=0; a later ack is not forwarded.
- Error/retry routing: slave returns s_err_i on master 1's read -> m_err_o=2'b10, m_ack_o=0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): slave never responds -> m_err_o[0] pulses exactly at stalled cycle 16, s_cyc_o=0 in ABORT, IDLE after master drops cyc; without the macro the bus stays granted after 1000 clk.

Source files
------------

// File: rtl/wb_arb_defs.sv
// ----------------------------------------------------------------------------
// wb_arb_defs
// Shared definitions for the Wishbone bus arbiter slice.
//   arb_state_e     : arbiter FSM state encodings (IDLE / GRANT / ABORT)
//   TIMEOUT_CYC_DEF : default watchdog limit in clk cycles
// ----------------------------------------------------------------------------
package wb_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;

endpackage : wb_arb_defs

// File: rtl/wb_rr_picker.sv
// ----------------------------------------------------------------------------
// wb_rr_picker
// Combinational round-robin priority encoder. The search starts at the
// position just above the last owner and wraps modulo NM, so the previous
// owner has the lowest priority.
// Ports:
//   req   [NM] : request vector
//   last  [NM] : one-hot previous owner
//   pick  [NM] : one-hot selected requester (zero when no request)
//   valid      : at least one request present
// ----------------------------------------------------------------------------
module wb_rr_picker #(
  parameter int NM = 2
) (
  input  logic [NM-1:0] req,
  input  logic [NM-1:0] last,
  output logic [NM-1:0] pick,
  output logic          valid
);

  always_comb begin
    int  last_idx;
    int  idx;
    logic found;
    pick     = '0;
    valid    = |req;
    last_idx = NM - 1;
    idx      = 0;
    found    = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (last[i]) last_idx = i;
    end
    for (int i = 1; i <= NM; i++) begin
      idx = (last_idx + i) % NM;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule : wb_rr_picker

// File: rtl/wb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// wb_bus_arbiter
// Round-robin arbiter sharing one Wishbone classic slave port among NM
// masters. Ownership is held for a whole cyc; one idle cycle separates owners.
// Optional feature macro: WB_ARB_TIMEOUT_EN -- watchdog that aborts a slave
// cycle stalled for TIMEOUT_CYC clocks, signalling err to the owner.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i   : per-master control [NM]
//   m_adr_i/m_dat_i/m_sel_i  : flattened per-master address/data/selects
//   m_dat_o                  : slave read data broadcast to all masters
//   m_ack_o/m_err_o/m_rty_o  : per-master terminations (owner only)
//   s_cyc_o..s_sel_o         : muxed slave request
//   s_dat_i/s_ack_i/s_err_i/s_rty_i : slave response
//   gnt_o                    : registered one-hot grant
// ----------------------------------------------------------------------------
module wb_bus_arbiter
  import wb_arb_defs::*;
#(
  parameter int NM          = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NM-1:0]          m_cyc_i,
  input  logic [NM-1:0]          m_stb_i,
  input  logic [NM-1:0]          m_we_i,
  input  logic [NM*AW-1:0]       m_adr_i,
  input  logic [NM*DW-1:0]       m_dat_i,
  input  logic [NM*(DW/8)-1:0]   m_sel_i,
  output logic [DW-1:0]          m_dat_o,
  output logic [NM-1:0]          m_ack_o,
  output logic [NM-1:0]          m_err_o,
  output logic [NM-1:0]          m_rty_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [AW-1:0]          s_adr_o,
  output logic [DW-1:0]          s_dat_o,
  output logic [DW/8-1:0]        s_sel_o,
  input  logic [DW-1:0]          s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_rty_i,
  output logic [NM-1:0]          gnt_o
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(NM);

  if (NM < 2 || NM > 8) begin : g_bad_nm
    $error("wb_bus_arbiter: NM must be in 2..8");
  end
  if (DW % 8 != 0) begin : g_bad_dw
    $error("wb_bus_arbiter: DW must be a multiple of 8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("wb_bus_arbiter: TIMEOUT_CYC must be at least 1");
  end

  arb_state_e    state_q, state_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [NM-1:0] last_q, last_d;
  logic [NM-1:0] pick;
  logic          pick_vld;
  logic [IW-1:0] gidx;
  logic          in_grant;
  logic          to_hit;

  wb_rr_picker #(.NM(NM)) u_picker (
    .req   (m_cyc_i),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q[i]) gidx = IW'(i);
    end
  end

  assign in_grant = (state_q == ST_GRANT);

  // Request path: granted master's inputs, forced quiet outside GRANT.
  assign s_cyc_o = in_grant & m_cyc_i[gidx];
  assign s_stb_o = in_grant & m_stb_i[gidx];
  assign s_we_o  = in_grant & m_we_i[gidx];
  assign s_adr_o = in_grant ? m_adr_i[gidx*AW +: AW] : '0;
  assign s_dat_o = in_grant ? m_dat_i[gidx*DW +: DW] : '0;
  assign s_sel_o = in_grant ? m_sel_i[gidx*SW +: SW] : '0;

  // Response path: terminations only reach the owner and only while the
  // slave actually sees a cycle; stray terminations are dropped.
  assign m_dat_o = s_dat_i;
  assign m_ack_o = {NM{s_cyc_o & s_ack_i}} & gnt_q;
  assign m_err_o = ({NM{s_cyc_o & s_err_i}} | {NM{to_hit}}) & gnt_q;
  assign m_rty_o = {NM{s_cyc_o & s_rty_i}} & gnt_q;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

  logic [CW-1:0] to_cnt_q;
  logic          s_term;

  assign s_term = s_ack_i | s_err_i | s_rty_i;
  assign to_hit = in_grant && (to_cnt_q == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (!rst || !in_grant || s_term || to_hit) begin
      to_cnt_q <= '0;
    end else if (s_cyc_o && s_stb_o) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= {1'b1, {(NM-1){1'b0}}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          gnt_d   = pick;
          last_d  = pick;
        end
      end
      ST_GRANT: begin
        // Owner release takes priority over a same-cycle watchdog hit.
        if (!m_cyc_i[gidx]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (to_hit) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!m_cyc_i[gidx]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt_o = gnt_q;

endmodule : wb_bus_arbiter

// File: tb/tb_wb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_bus_arbiter
// Scoreboard bench for wb_bus_arbiter with two masters. Each request pushes
// its expected slave-side transaction; the queue order is the expected grant
// order, popped when the slave side shows the cycle.
// ----------------------------------------------------------------------------
module tb_wb_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NM-1:0]        m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]     m_adr;
  logic [NM*DW-1:0]     m_dat;
  logic [NM*(DW/8)-1:0] m_sel;
  logic [DW-1:0]        m_dat_o;
  logic [NM-1:0]        m_ack_o, m_err_o, m_rty_o;
  logic                 s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]        s_adr_o;
  logic [DW-1:0]        s_dat_o;
  logic [DW/8-1:0]      s_sel_o;
  logic [DW-1:0]        s_dat_i;
  logic                 s_ack_i, s_err_i, s_rty_i;
  logic [NM-1:0]        gnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  xfer_t exp_q[$];

  wb_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT_CYC(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .s_rty_i (s_rty_i),
    .gnt_o   (gnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_scyc(input int bound, output int waited);
    waited = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (s_cyc_o === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic req(input int k, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat);
    xfer_t x;
    m_cyc[k]         = 1'b1;
    m_stb[k]         = 1'b1;
    m_we[k]          = we;
    m_adr[k*AW +: AW] = adr;
    m_dat[k*DW +: DW] = dat;
    m_sel[k*4 +: 4]  = 4'hF;
    x.m = k; x.we = we; x.adr = adr; x.dat = dat;
    exp_q.push_back(x);
  endtask

  task automatic drop(input int k);
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
  endtask

  // Consume the termination edge, then release the owner; ends in IDLE.
  task automatic finish_xfer(input int k);
    step();
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    drop(k);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    repeat (3) step();
    n_tests++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt_o=%b s_cyc_o=%b s_stb_o=%b expected 00/0/0",
               gnt_o, s_cyc_o, s_stb_o);
    end
    n_tests++;
    if ((m_ack_o | m_err_o | m_rty_o) !== 2'b00 || s_adr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_terms: ack=%b err=%b rty=%b s_adr_o=%h expected all 0",
               m_ack_o, m_err_o, m_rty_o, s_adr_o);
    end
    rst = 1'b1;
    repeat (2) step();
    n_tests++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: gnt_o=%b s_cyc_o=%b expected 00/0", gnt_o, s_cyc_o);
    end
  endtask

  task automatic test_single_write();
    int    w;
    xfer_t e;
    req(1, 1'b1, 32'h4, 32'h0000_00A5);
    wait_scyc(5, w);
    n_tests++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL write_latency: cycles=%0d expected 1", w);
    end
    e = exp_q.pop_front();
    n_tests++;
    if (gnt_o !== (2'b01 << e.m) || s_adr_o !== e.adr || s_we_o !== e.we ||
        s_dat_o !== e.dat || s_sel_o !== 4'hF) begin
      n_fail++;
      $display("FAIL write_bus: gnt=%b adr=%h we=%b dat=%h sel=%h expected %b/%h/%b/%h/f",
               gnt_o, s_adr_o, s_we_o, s_dat_o, s_sel_o, 2'b01 << e.m, e.adr, e.we, e.dat);
    end
    step();
    n_tests++;
    if (m_ack_o !== 2'b00 || s_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL write_wait: m_ack_o=%b s_cyc_o=%b expected 00/1", m_ack_o, s_cyc_o);
    end
    step();
    s_ack_i = 1'b1;
    #1;
    n_tests++;
    if (m_ack_o !== 2'b10) begin
      n_fail++;
      $display("FAIL write_ack: m_ack_o=%b expected 10", m_ack_o);
    end
    step();
    s_ack_i = 1'b0;
    drop(1);
    #1;
    n_tests++;
    if (gnt_o !== 2'b10 || m_ack_o !== 2'b00) begin
      n_fail++;
      $display("FAIL write_hold: gnt_o=%b m_ack_o=%b expected 10/00", gnt_o, m_ack_o);
    end
    step();
    n_tests++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_release: gnt_o=%b s_cyc_o=%b expected 00/0", gnt_o, s_cyc_o);
    end
  endtask

  task automatic test_contention();
    int          w;
    xfer_t       e;
    logic [31:0] rd;
    req(0, 1'b0, 32'h10, 32'h0);
    req(1, 1'b0, 32'h20, 32'h0);
    for (int it = 0; it < 4; it++) begin
      wait_scyc(5, w);
      n_tests++;
      if (w !== 1 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cont_grant_%0d: latency=%0d queued=%0d expected 1/>0",
                 it, w, exp_q.size());
        return;
      end
      e = exp_q.pop_front();
      n_tests++;
      if (gnt_o !== (2'b01 << e.m) || s_adr_o !== e.adr || s_we_o !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_owner_%0d: gnt=%b adr=%h expected %b/%h",
                 it, gnt_o, s_adr_o, 2'b01 << e.m, e.adr);
      end
      rd = (e.m == 0) ? 32'h11 : 32'h22;
      s_dat_i = rd;
      s_ack_i = 1'b1;
      #1;
      n_tests++;
      if (m_ack_o !== (2'b01 << e.m) || m_dat_o !== rd) begin
        n_fail++;
        $display("FAIL cont_ack_%0d: m_ack_o=%b m_dat_o=%h expected %b/%h",
                 it, m_ack_o, m_dat_o, 2'b01 << e.m, rd);
      end
      finish_xfer(e.m);
      n_tests++;
      if (s_cyc_o !== 1'b0 || gnt_o !== 2'b00) begin
        n_fail++;
        $display("FAIL cont_dead_%0d: s_cyc_o=%b gnt_o=%b expected 0/00", it, s_cyc_o, gnt_o);
      end
      if (it < 2) req(e.m, 1'b0, e.adr, 32'h0);
    end
  endtask

  task automatic test_err_rty();
    int    w;
    xfer_t e;
    req(1, 1'b0, 32'h30, 32'h0);
    wait_scyc(5, w);
    e = exp_q.pop_front();
    n_tests++;
    if (w < 0 || gnt_o !== (2'b01 << e.m) || s_adr_o !== e.adr) begin
      n_fail++;
      $display("FAIL err_grant: wait=%0d gnt=%b adr=%h expected %b/%h",
               w, gnt_o, s_adr_o, 2'b01 << e.m, e.adr);
    end
    s_err_i = 1'b1;
    #1;
    n_tests++;
    if (m_err_o !== 2'b10 || m_ack_o !== 2'b00 || m_rty_o !== 2'b00) begin
      n_fail++;
      $display("FAIL err_route: err=%b ack=%b rty=%b expected 10/00/00",
               m_err_o, m_ack_o, m_rty_o);
    end
    finish_xfer(1);
    req(0, 1'b0, 32'h34, 32'h0);
    wait_scyc(5, w);
    e = exp_q.pop_front();
    s_rty_i = 1'b1;
    #1;
    n_tests++;
    if (w < 0 || m_rty_o !== (2'b01 << e.m) || m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rty_route: wait=%0d rty=%b ack=%b err=%b expected %b/00/00",
               w, m_rty_o, m_ack_o, m_err_o, 2'b01 << e.m);
    end
    finish_xfer(0);
    s_ack_i = 1'b1;
    #1;
    n_tests++;
    if (m_ack_o !== 2'b00) begin
      n_fail++;
      $display("FAIL stray_ack: m_ack_o=%b expected 00", m_ack_o);
    end
    s_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int    w;
    xfer_t e;
    req(0, 1'b0, 32'h40, 32'h0);
    wait_scyc(5, w);
    e = exp_q.pop_front();
    n_tests++;
    if (w < 0 || gnt_o !== (2'b01 << e.m)) begin
      n_fail++;
      $display("FAIL rmid_grant: wait=%0d gnt=%b expected %b", w, gnt_o, 2'b01 << e.m);
    end
    step();
    rst = 1'b0;
    drop(0);
    step();
    n_tests++;
    if (s_cyc_o !== 1'b0 || gnt_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_drop: s_cyc_o=%b gnt_o=%b expected 0/00", s_cyc_o, gnt_o);
    end
    rst = 1'b1;
    s_ack_i = 1'b1;
    #1;
    n_tests++;
    if (m_ack_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_late_ack: m_ack_o=%b expected 00", m_ack_o);
    end
    s_ack_i = 1'b0;
    // Pointer was reset, so master 0 must win a simultaneous request.
    req(0, 1'b0, 32'h50, 32'h0);
    req(1, 1'b0, 32'h54, 32'h0);
    for (int it = 0; it < 2; it++) begin
      wait_scyc(5, w);
      e = exp_q.pop_front();
      n_tests++;
      if (w < 0 || gnt_o !== (2'b01 << e.m) || s_adr_o !== e.adr) begin
        n_fail++;
        $display("FAIL rmid_order_%0d: wait=%0d gnt=%b adr=%h expected %b/%h",
                 it, w, gnt_o, s_adr_o, 2'b01 << e.m, e.adr);
      end
      s_ack_i = 1'b1;
      finish_xfer(e.m);
    end
  endtask

  task automatic test_timeout();
    int    w;
    xfer_t e;
    req(0, 1'b0, 32'h60, 32'h0);
    wait_scyc(5, w);
    e = exp_q.pop_front();
    n_tests++;
    if (w < 0 || gnt_o !== (2'b01 << e.m)) begin
      n_fail++;
      $display("FAIL to_grant: wait=%0d gnt=%b expected %b", w, gnt_o, 2'b01 << e.m);
    end
`ifdef WB_ARB_TIMEOUT_EN
    for (int n = 1; n <= 20; n++) begin
      logic [1:0] exp_err;
      step();
      exp_err = (n == 16) ? 2'b01 : 2'b00;
      n_tests++;
      if (m_err_o !== exp_err) begin
        n_fail++;
        $display("FAIL to_err_%0d: m_err_o=%b expected %b", n, m_err_o, exp_err);
      end
      if (n == 17) begin
        n_tests++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
          n_fail++;
          $display("FAIL to_abort: s_cyc_o=%b s_stb_o=%b expected 0/0", s_cyc_o, s_stb_o);
        end
      end
    end
    drop(0);
    step();
    n_tests++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_idle: gnt_o=%b s_cyc_o=%b expected 00/0", gnt_o, s_cyc_o);
    end
`else
    repeat (1000) step();
    n_tests++;
    if (s_cyc_o !== 1'b1 || gnt_o !== 2'b01 || m_err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL hung_hold: s_cyc_o=%b gnt_o=%b m_err_o=%b expected 1/01/00",
               s_cyc_o, gnt_o, m_err_o);
    end
    s_ack_i = 1'b1;
    finish_xfer(0);
    n_tests++;
    if (gnt_o !== 2'b00) begin
      n_fail++;
      $display("FAIL hung_release: gnt_o=%b expected 00", gnt_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_err_rty();
    test_reset_mid();
    test_timeout();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wb_bus_arbiter
